// File: rtl/calc_pkg.sv
// calc_pkg: shared key codes, ALU op codes, sequencer state encoding and
// display constants for the four-digit BCD calculator.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_DIV = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_CLR = 4'd15;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;

    localparam logic [2:0]  MAX_DIGITS  = 3'd4;
    localparam logic [15:0] ERR_PATTERN = 16'hEEEE;

    typedef enum logic [2:0] {
        ST_ENTER_A  = 3'd0,
        ST_OP_SEL   = 3'd1,
        ST_ENTER_B  = 3'd2,
        ST_EXEC     = 3'd3,
        ST_SHOW_RES = 3'd4,
        ST_ERROR    = 3'd5
    } state_e;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] k);
        return (k >= KEY_ADD) && (k <= KEY_DIV);
    endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// bcd_entry_reg: 4-digit BCD operand register. Digits shift in from the
// right until four have been taken, then further digits are dropped.
// Clear and shift may coincide (clear, then take the digit); a parallel
// load marks the operand as full.
module bcd_entry_reg
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        clr_i,
    input  logic        shift_i,
    input  logic [3:0]  digit_i,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    output logic [15:0] val_o,
    output logic [15:0] val_nxt_o
);

    logic [15:0] val_q, val_d, base_val;
    logic [2:0]  cnt_q, cnt_d, base_cnt;

    // Next operand value: clear first, then load or shift-in a digit.
    always_comb begin
        base_val = clr_i ? 16'd0 : val_q;
        base_cnt = clr_i ? 3'd0  : cnt_q;
        val_d    = base_val;
        cnt_d    = base_cnt;
        if (load_i) begin
            val_d = load_val_i;
            cnt_d = MAX_DIGITS;
        end else if (shift_i && (base_cnt < MAX_DIGITS)) begin
            val_d = {base_val[11:0], digit_i};
            cnt_d = base_cnt + 3'd1;
        end
    end

    // Operand value and digit count registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            val_q <= '0;
            cnt_q <= '0;
        end else begin
            val_q <= val_d;
            cnt_q <= cnt_d;
        end
    end

    assign val_o     = val_q;
    assign val_nxt_o = val_d;

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: calculator control FSM. Builds operand 1, operator and
// operand 2 from key strobes, launches the ALU, then shows the result or the
// error pattern. Define CALC_CHAIN_EN to let an operator key pressed while a
// result is shown continue the calculation with that result as operand 1.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int ALU_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] alu_num1,
    output logic [15:0] alu_num2,
    output logic [3:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_res,
    input  logic        alu_err,
    output logic [15:0] display,
    output logic        busy,
    output logic        err
);

    localparam int TW = (ALU_TIMEOUT < 1) ? 1 : $clog2(ALU_TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [15:0]   res_q, res_d, disp_q, disp_d;
    logic          start_q, start_d, pend_q, pend_d, pend_now;
    logic          busy_q, err_q;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          n1_clr, n1_shift, n1_load, n2_clr, n2_shift;
    logic [15:0]   n1_val, n1_nxt, n2_val, n2_nxt;

    logic          k_dig, k_op, k_eq, k_clr, done_ok, tmo_hit;

    assign k_dig = key_valid && is_digit(key_code);
    assign k_op  = key_valid && is_op(key_code);
    assign k_eq  = key_valid && (key_code == KEY_EQ);
    assign k_clr = key_valid && (key_code == KEY_CLR);

    // Done is only meaningful once the launch pulse has gone out.
    assign done_ok = (state_q == ST_EXEC) && !start_q && alu_done;
    assign tmo_hit = (state_q == ST_EXEC) && (tmo_q == TW'(ALU_TIMEOUT));

    bcd_entry_reg u_num1 (
        .clk(clk), .resetn(resetn), .clr_i(n1_clr), .shift_i(n1_shift),
        .digit_i(key_code), .load_i(n1_load), .load_val_i(res_q),
        .val_o(n1_val), .val_nxt_o(n1_nxt)
    );

    bcd_entry_reg u_num2 (
        .clk(clk), .resetn(resetn), .clr_i(n2_clr), .shift_i(n2_shift),
        .digit_i(key_code), .load_i(1'b0), .load_val_i(16'd0),
        .val_o(n2_val), .val_nxt_o(n2_nxt)
    );

    // Next state, operand control and display source selection.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        res_d    = res_q;
        start_d  = 1'b0;
        pend_d   = pend_q;
        pend_now = 1'b0;
        tmo_d    = tmo_q;
        n1_clr   = 1'b0;
        n1_shift = 1'b0;
        n1_load  = 1'b0;
        n2_clr   = 1'b0;
        n2_shift = 1'b0;

        if (k_clr && (state_q != ST_EXEC)) begin
            n1_clr  = 1'b1;
            n2_clr  = 1'b1;
            op_d    = OP_ADD;
            res_d   = '0;
            state_d = ST_ENTER_A;
        end else begin
            unique case (state_q)
                ST_ENTER_A: begin
                    if (k_dig) begin
                        n1_shift = 1'b1;
                    end else if (k_op) begin
                        op_d    = key_code - KEY_ADD;
                        state_d = ST_OP_SEL;
                    end
                end
                ST_OP_SEL: begin
                    if (k_op) begin
                        op_d = key_code - KEY_ADD;
                    end else if (k_dig) begin
                        n2_clr   = 1'b1;
                        n2_shift = 1'b1;
                        state_d  = ST_ENTER_B;
                    end
                end
                ST_ENTER_B: begin
                    if (k_dig) begin
                        n2_shift = 1'b1;
                    end else if (k_eq) begin
                        start_d = 1'b1;
                        tmo_d   = '0;
                        pend_d  = 1'b0;
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // A clear pressed mid-operation waits for the ALU to finish.
                    pend_now = pend_q | k_clr;
                    pend_d   = pend_now;
                    tmo_d    = tmo_q + 1'b1;
                    if (done_ok || tmo_hit) begin
                        pend_d = 1'b0;
                        if (pend_now) begin
                            n1_clr  = 1'b1;
                            n2_clr  = 1'b1;
                            op_d    = OP_ADD;
                            res_d   = '0;
                            state_d = ST_ENTER_A;
                        end else if (done_ok && !alu_err) begin
                            res_d   = alu_res;
                            state_d = ST_SHOW_RES;
                        end else begin
                            state_d = ST_ERROR;
                        end
                    end
                end
                ST_SHOW_RES: begin
                    if (k_dig) begin
                        n1_clr   = 1'b1;
                        n1_shift = 1'b1;
                        n2_clr   = 1'b1;
                        op_d     = OP_ADD;
                        state_d  = ST_ENTER_A;
                    end
`ifdef CALC_CHAIN_EN
                    else if (k_op) begin
                        n1_load = 1'b1;
                        op_d    = key_code - KEY_ADD;
                        state_d = ST_OP_SEL;
                    end
`endif
                end
                ST_ERROR: ;
                default:  state_d = ST_ENTER_A;
            endcase
        end

        unique case (state_d)
            ST_ENTER_A, ST_OP_SEL: disp_d = n1_nxt;
            ST_ENTER_B, ST_EXEC:   disp_d = n2_nxt;
            ST_SHOW_RES:           disp_d = res_d;
            default:               disp_d = ERR_PATTERN;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_ENTER_A;
            op_q    <= '0;
            res_q   <= '0;
            disp_q  <= '0;
            start_q <= 1'b0;
            pend_q  <= 1'b0;
            tmo_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            disp_q  <= disp_d;
            start_q <= start_d;
            pend_q  <= pend_d;
            tmo_q   <= tmo_d;
            busy_q  <= (state_d == ST_EXEC);
            err_q   <= (state_d == ST_ERROR);
        end
    end

    assign alu_num1  = n1_val;
    assign alu_num2  = n2_val;
    assign alu_op    = op_q;
    assign alu_start = start_q;
    assign display   = disp_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed and randomized key sequences against an
// abstract calculator model; launch operands are checked by a monitor.
module tb_calc_sequencer;

    localparam int T = 20;

    logic        clk = 1'b0, resetn = 1'b0, key_valid = 1'b0;
    logic [3:0]  key_code = '0;
    logic        alu_done = 1'b0, alu_err = 1'b0;
    logic [15:0] alu_res = '0;
    logic [15:0] alu_num1, alu_num2, display;
    logic [3:0]  alu_op;
    logic        alu_start, busy, err;

    always #5 clk = ~clk;

    calc_sequencer #(.ALU_TIMEOUT(T)) dut (
        .clk(clk), .resetn(resetn), .key_valid(key_valid), .key_code(key_code),
        .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_op(alu_op),
        .alu_start(alu_start), .alu_done(alu_done), .alu_res(alu_res),
        .alu_err(alu_err), .display(display), .busy(busy), .err(err)
    );

    int checks = 0, errors = 0;

    typedef enum {MA, MOP, MB, MX, MR, ME} mode_t;
    mode_t mode = MA;
    int a = 0, na = 0, b = 0, nb = 0, op = 0, res = 0;

    logic [35:0] exp_q[$];
    logic [35:0] mon_e;
    logic        prev_start = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int bcd2int(input int v);
        return ((v >> 12) & 15) * 1000 + ((v >> 8) & 15) * 100 + ((v >> 4) & 15) * 10 + (v & 15);
    endfunction

    function automatic int int2bcd(input int v);
        return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    function automatic logic [15:0] exp_disp();
        case (mode)
            MA, MOP: return 16'(a);
            MB, MX:  return 16'(b);
            MR:      return 16'(res);
            default: return 16'hEEEE;
        endcase
    endfunction

    task automatic model_reset();
        a = 0; na = 0; b = 0; nb = 0; op = 0; res = 0; mode = MA;
    endtask

    task automatic model_key(input int c);
        if (c == 15 && mode != MX) begin
            model_reset();
        end else begin
            case (mode)
                MA: if (c <= 9) begin
                        if (na < 4) begin a = a * 16 + c; na++; end
                    end else if (c <= 13) begin
                        op = c - 10; mode = MOP;
                    end
                MOP: if (c <= 13 && c >= 10) op = c - 10;
                     else if (c <= 9) begin b = c; nb = 1; mode = MB; end
                MB: if (c <= 9) begin
                        if (nb < 4) begin b = b * 16 + c; nb++; end
                    end else if (c == 14) mode = MX;
                MR: if (c <= 9) begin
                        a = c; na = 1; b = 0; nb = 0; op = 0; mode = MA;
                    end
`ifdef CALC_CHAIN_EN
                    else if (c >= 10 && c <= 13) begin
                        a = res; na = 4; op = c - 10; mode = MOP;
                    end
`endif
                default: ;
            endcase
        end
    endtask

    // Key applied for one cycle starting at a falling edge.
    task automatic press(input int c);
        key_valid = 1'b1;
        key_code  = 4'(c);
        @(negedge clk);
        key_valid = 1'b0;
        model_key(c);
        chk("display_after_key", display, exp_disp());
    endtask

    // What a correct ALU would answer for the current operands.
    task automatic alu_model(output logic [15:0] r, output logic e);
        int x, y, z;
        x = bcd2int(a); y = bcd2int(b); z = 0; e = 1'b0;
        case (op)
            0: z = x + y;
            1: begin z = x - y; if (z < 0) e = 1'b1; end
            2: z = x * y;
            default: if (y == 0) e = 1'b1; else z = x / y;
        endcase
        if (z > 9999) e = 1'b1;
        r = e ? 16'd0 : 16'(int2bcd(z));
    endtask

    // '=' then ALU reply in cycle k after the launch (k < 0: never reply).
    // clr_at >= 0 presses 'C' that many cycles after the launch.
    task automatic run_exec(input int k, input int clr_at);
        logic [15:0] r;
        logic        e;
        bit          cleared;
        cleared = 0;
        alu_model(r, e);
        exp_q.push_back({16'(a), 16'(b), 4'(op)});
        press(14);
        chk("busy_in_exec", {15'd0, busy}, 16'd1);
        if (k < 0) begin
            repeat (T) @(negedge clk);
            chk("no_err_before_timeout", {15'd0, err}, 16'd0);
            chk("busy_before_timeout", {15'd0, busy}, 16'd1);
            @(negedge clk);
            mode = ME;
            chk("err_after_timeout", {15'd0, err}, 16'd1);
            chk("display_after_timeout", display, exp_disp());
        end else begin
            if (clr_at >= 0 && clr_at < k) begin
                repeat (clr_at) @(negedge clk);
                press(15);
                cleared = 1;
                repeat (k - clr_at - 1) @(negedge clk);
            end else begin
                repeat (k) @(negedge clk);
            end
            alu_done = 1'b1; alu_err = e; alu_res = r;
            @(negedge clk);
            alu_done = 1'b0; alu_err = 1'b0; alu_res = 16'($urandom);
            if (cleared) model_reset();
            else if (e) mode = ME;
            else begin res = r; mode = MR; end
            chk("display_after_done", display, exp_disp());
            chk("err_after_done", {15'd0, err}, {15'd0, mode == ME});
            chk("busy_after_done", {15'd0, busy}, 16'd0);
        end
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk(nm, display, 16'd0);
        chk(nm, alu_num1, 16'd0);
        chk(nm, alu_num2, 16'd0);
        chk(nm, {11'd0, alu_op, alu_start}, 16'd0);
        chk(nm, {14'd0, busy, err}, 16'd0);
    endtask

    // Monitor: every launch pulse must match the next expected operand set.
    always @(negedge clk) begin
        if (resetn && alu_start) begin
            chk("start_single_pulse", {15'd0, prev_start}, 16'd0);
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL start_unexpected got num1 %h num2 %h expected no launch", alu_num1, alu_num2);
            end else begin
                mon_e = exp_q.pop_front();
                chk("alu_num1", alu_num1, mon_e[35:20]);
                chk("alu_num2", alu_num2, mon_e[19:4]);
                chk("alu_op", {12'd0, alu_op}, {12'd0, mon_e[3:0]});
            end
        end
        prev_start <= alu_start;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, ko, ca;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset_outputs");
        resetn = 1'b1;
        @(negedge clk);

        // 12 + 34, ALU answers 3 cycles after launch
        press(1); press(2); press(10); press(3); press(4);
        run_exec(3, -1);
        chk("result_0046", display, 16'h0046);

        // saturating entry
        press(15); press(1); press(2); press(3); press(4); press(5);
        chk("saturate_1234", display, 16'h1234);

        // divide by zero, digits ignored in error, clear exits
        press(15); press(9); press(13); press(0);
        run_exec(2, -1);
        chk("err_display", display, 16'hEEEE);
        press(7);
        press(15);
        chk("clear_from_error", display, 16'd0);

        // timeout, then done on the timeout cycle wins
        press(1); press(10); press(2);
        run_exec(-1, -1);
        press(15);
        press(1); press(10); press(2);
        run_exec(T, -1);
        chk("done_beats_timeout", display, 16'h0003);

        // clear pending during exec, op reselect and leading zero
        press(15); press(0); press(3); press(12); press(10); press(4);
        run_exec(4, 1);
        press(5);

        // result 7 then '*', 2, '='
        press(15); press(3); press(10); press(4);
        run_exec(2, -1);
        press(12); press(2);
        if (mode == MB) run_exec(2, -1);
        else press(14);

        // reset during exec, late done ignored
        press(15); press(5); press(11); press(3);
        exp_q.push_back({16'(a), 16'(b), 4'(op)});
        press(14);
        #2 resetn = 1'b0;
        @(negedge clk);
        chk_zero_outputs("reset_in_exec");
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        alu_done = 1'b1; alu_res = 16'h1234;
        @(negedge clk);
        alu_done = 1'b0;
        @(negedge clk);
        model_reset();
        chk_zero_outputs("done_after_reset");

        // randomized calculations
        for (int it = 0; it < 40; it++) begin
            press(15);
            if ($urandom_range(0, 3) == 0) press(14);
            nd = $urandom_range(1, 5);
            for (int i = 0; i < nd; i++) press($urandom_range(0, 9));
            press($urandom_range(10, 13));
            if ($urandom_range(0, 2) == 0) press($urandom_range(10, 13));
            nd = $urandom_range(1, 5);
            for (int i = 0; i < nd; i++) begin
                press($urandom_range(0, 9));
                if ($urandom_range(0, 5) == 0) press($urandom_range(10, 14) == 14 ? 10 : 11);
            end
            ko = $urandom_range(1, 5);
            ca = ($urandom_range(0, 9) == 0) ? $urandom_range(0, ko - 1) : -1;
            run_exec(ko, ca);
            if (mode == MR && $urandom_range(0, 1) == 1) press($urandom_range(0, 9));
        end

        chk("launch_queue_empty", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Main control FSM of the four-digit BCD calculator. It sits between the keyboard controller (decoded key code plus read strobe) and the ALU, assembling operand 1, the operator and operand 2 from key presses. It launches the ALU with a start/done handshake, latches the result or error, and drives the 16-bit BCD word consumed by the display multiplexer.

## Interface
- ALU_TIMEOUT, default 255: cycles to wait for `alu_done` after `alu_start` before declaring an error.
- clk  in  1  system clock (internal LF oscillator domain).
- resetn  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe; `key_code` is valid in that cycle.
- key_code  in  4  key codes:
  - 0–9 digit
  - 10 '+', 11 '-', 12 '*', 13 '/'
  - 14 '=', 15 'C'
- alu_num1  out  16  operand 1, 4 BCD digits.
- alu_num2  out  16  operand 2, 4 BCD digits.
- alu_op  out  4  operator: 0 add, 1 sub, 2 mul, 3 div.
- alu_start  out  1  one-cycle launch pulse.
- alu_done  in  1  ALU result valid, pulse or level.
- alu_res  in  16  ALU BCD result; sampled when `alu_done` is high.
- alu_err  in  1  ALU error (overflow or divide by zero); sampled with `alu_done`.
- display  out  16  BCD word to show.
- busy  out  1  high while in EXEC.
- err  out  1  high while in ERROR.

## Operation
- States: ENTER_A, OP_SEL, ENTER_B, EXEC, SHOW_RES, ERROR. Reset state is ENTER_A.
- Digit entry:
  - The value becomes `(val << 4) | digit`.
  - A per-operand count saturates at 4; further digits are ignored, with no wrap.
  - A leading 0 counts as a digit.
- ENTER_A:
  - digit → entry into num1.
  - op key → latch `alu_op`, go to OP_SEL.
  - '=' → ignored.
- OP_SEL:
  - op key → replaces `alu_op`.
  - digit → clear num2, enter the digit, go to ENTER_B.
  - '=' → ignored.
- ENTER_B:
  - digit → entry into num2.
  - op key → ignored.
  - '=' → go to EXEC.
- EXEC:
  - `alu_start` pulses on the entry cycle.
  - On `alu_done`: if `alu_err`, go to ERROR; otherwise latch `alu_res` and go to SHOW_RES.
  - A timeout counter reaching ALU_TIMEOUT → ERROR.
  - Digit and op keys are ignored.
  - 'C' is latched as pending and applied when EXEC exits; the exit then goes to ENTER_A instead.
- SHOW_RES:
  - digit → clear num1/num2/op, num1 = digit, go to ENTER_A.
  - '=' → ignored.
- ERROR: only 'C' exits.
- 'C' in any state except EXEC → clear num1, num2, op, counts and result; go to ENTER_A next cycle.
- Display source by state:
  - ENTER_A, OP_SEL: num1.
  - ENTER_B, EXEC: num2.
  - SHOW_RES: latched result.
  - ERROR: 16'hEEEE.

## Timing
- All outputs are registered. Reset values: every output 0; state ENTER_A.
- A key accepted in cycle N updates state, operands and `display` at the edge ending cycle N.
- `alu_start` is high exactly one cycle: the first EXEC cycle.
- `alu_num1`, `alu_num2` and `alu_op` are stable from that cycle until EXEC exits.
- `alu_done` is honoured only in EXEC and no earlier than the cycle after `alu_start`. `alu_done` outside EXEC is ignored.
- From the `alu_done` cycle, `display` shows the result one cycle later.
- Timeout: ERROR is entered when the counter reaches ALU_TIMEOUT cycles after `alu_start` with no `alu_done`.
- If `alu_done` and the timeout occur in the same cycle, `alu_done` wins.
- `key_valid` in consecutive cycles: each strobe is processed in order.
- An asynchronous reset mid-EXEC abandons the operation; a later `alu_done` is ignored.

## Configuration
- `CALC_CHAIN_EN` defined: an op key in SHOW_RES copies the result into num1 (count = 4), latches the op and goes to OP_SEL.
- `CALC_CHAIN_EN` undefined: an op key in SHOW_RES is ignored.

## Structure
- Package `calc_pkg` holds:
  - key code constants (KEY_ADD … KEY_CLR);
  - op codes;
  - state encoding;
  - ERR_PATTERN = 16'hEEEE.
- Sub-module `bcd_entry_reg` holds a 4-digit shift register with saturating count, plus clear and parallel-load inputs. It is instantiated twice: num1, and num2.

## Test plan
- Keys 1,2,'+',3,4,'=', with `alu_done` 3 cycles after start and res 0x0046:
  - `alu_start` is a single pulse with num1 = 0x0012, num2 = 0x0034, op = 0;
  - `display` = 0x0046 the cycle after done.
- Keys 1,2,3,4,5: num1 = 0x1234, count = 4, and the fifth digit is ignored.
- Keys 9,'/',0,'=', with `alu_done` and `alu_err` = 1: state ERROR, `err` = 1, `display` = 0xEEEE. Digits are ignored; 'C' → ENTER_A with `display` = 0.
- '=' with no `alu_done` for ALU_TIMEOUT cycles → ERROR. 'C' pressed during EXEC → ENTER_A at exit, with the result discarded.
- Reset asserted in EXEC, then released; `alu_done` pulses later: all outputs stay 0 and the state is ENTER_A.
- Result 0x0007 shown, then '*',2,'=':
  - with `CALC_CHAIN_EN`: num1 = 0x0007, num2 = 0x0002, op = 2;
  - without it: the '*' is ignored, and 2 starts a new num1 = 0x0002.
